// File: rtl/lu_arbiter_pkg.sv
// Shared types and constants for the logic-unit arbiter: opcodes, sequencer states,
// and the id-width helper used by both the interface and the top.
package lu_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_e;

   // Requester-index width; a single requester still gets a 1-bit id.
   function automatic int idw(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lu_arbiter_if.sv
// Request/response bundle between the requesters and lu_arbiter.
// slave = arbiter side, master = client side.
interface lu_arbiter_if import lu_pkg::*; #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int IDW = idw(N);

   logic [N-1:0]      req_valid_i;
   logic [N-1:0]      req_ready_o;
   logic [OP_W*N-1:0] req_op_i;
   logic [W*N-1:0]    req_a_i;
   logic [W*N-1:0]    req_b_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [W-1:0]      rsp_data_o;
   logic [IDW-1:0]    rsp_id_o;
   logic              rsp_err_o;

   modport slave (
      input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
   );

   modport master (
      output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
   );

endinterface

// File: rtl/lu_arbiter_gate_bank.sv
// Combinational gate bank: bitwise AND/OR/NOT/NAND/NOR/XOR over W bits.
// Opcodes 6 and 7 return zero with err set.
module lu_gate_bank import lu_pkg::*; #(
   parameter int W = 8
) (
   input  logic [OP_W-1:0] op_i,
   input  logic [W-1:0]    a_i,
   input  logic [W-1:0]    b_i,
   output logic [W-1:0]    y_o,
   output logic            err_o
);

   always_comb begin
      y_o   = '0;
      err_o = 1'b0;
      case (op_i)
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_NOT:  y_o = ~a_i;
         OP_NAND: y_o = ~(a_i & b_i);
         OP_NOR:  y_o = ~(a_i | b_i);
         OP_XOR:  y_o = a_i ^ b_i;
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/lu_arbiter.sv
// Round-robin arbiter sharing one lu_gate_bank among N requesters (IDLE->EXEC->RESP).
// Optional per-requester saturating grant counters when LU_ARB_STATS_EN is defined.
module lu_arbiter import lu_pkg::*; #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   lu_arbiter_if.slave       bus,
   output logic              busy_o
`ifdef LU_ARB_STATS_EN
   ,
   output logic [CNT_W*N-1:0] grant_cnt_o
`endif
);

   localparam int IDW = idw(N);

   if (N < 1 || W < 1 || CNT_W < 1) begin : g_bad_param
      $error("lu_arbiter: N, W and CNT_W must all be >= 1");
   end

   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] win;
   logic           found;
   logic           accept;

   logic [OP_W-1:0] op_q;
   logic [W-1:0]    a_q, b_q;
   logic [IDW-1:0]  id_q;
   logic            rsp_valid_q;
   logic [W-1:0]    rsp_data_q;
   logic            rsp_err_q;

   logic [W-1:0]    gb_y;
   logic            gb_err;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(rr_ptr_q) + k) % N;
         if (!found && bus.req_valid_i[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   assign accept   = (state_q == S_IDLE) && rst_ni && found;
   assign rr_ptr_d = (win == IDW'(N - 1)) ? '0 : win + 1'b1;

   always_comb begin
      bus.req_ready_o = '0;
      if (accept) bus.req_ready_o[win] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (found) state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  if (bus.rsp_ready_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            rr_ptr_q <= rr_ptr_d;
            op_q     <= bus.req_op_i[OP_W*win +: OP_W];
            a_q      <= bus.req_a_i[W*win +: W];
            b_q      <= bus.req_b_i[W*win +: W];
            id_q     <= win;
         end
         if (state_q == S_EXEC) begin
            rsp_data_q  <= gb_y;
            rsp_err_q   <= gb_err;
            rsp_valid_q <= 1'b1;
         end else if (state_q == S_RESP && bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   lu_gate_bank #(.W(W)) u_gate_bank (
      .op_i  (op_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .y_o   (gb_y),
      .err_o (gb_err)
   );

   // id only moves on accept, so it stays stable for the whole response phase.
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_data_o  = rsp_data_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.rsp_id_o    = id_q;
   assign busy_o          = (state_q != S_IDLE);

`ifdef LU_ARB_STATS_EN
   for (genvar i = 0; i < N; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clk_i) begin
         if (!rst_ni)
            cnt_q <= '0;
         else if (accept && win == IDW'(i) && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
      end
      assign grant_cnt_o[CNT_W*i +: CNT_W] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_lu_arbiter.sv
// Randomized + directed bench for lu_arbiter with a transaction-level scoreboard.
// Build with LU_ARB_STATS_EN to also check the saturating grant counters (CNT_W=2).
module tb_lu_arbiter;
   import lu_pkg::*;

   localparam int N = 4;
   localparam int W = 8;
`ifdef LU_ARB_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   always #5 clk = ~clk;

   lu_arbiter_if #(.N(N), .W(W)) bus();
`ifdef LU_ARB_STATS_EN
   logic [CNT_W*N-1:0] gcnt;
`endif

   lu_arbiter #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
`ifdef LU_ARB_STATS_EN
      .grant_cnt_o (gcnt),
`endif
      .bus         (bus),
      .busy_o      (busy)
   );

   typedef struct {
      int         id;
      logic [W-1:0] d;
      logic       e;
   } rsp_t;

   logic [N-1:0] vld;
   logic [2:0]   op_m [N];
   logic [W-1:0] a_m  [N];
   logic [W-1:0] b_m  [N];
   logic         rsp_rdy;
   bit           hold_all, rst_prev;
   int           rr_m, outst, since, cyc_n, n_hs;
   int           cnt_m [N];
   rsp_t         exp_q [$];
   int           glog [$];
   int           gcyc [$];
   logic [W-1:0] last_d;
   int           last_id;
   logic         last_e;
   int           n_chk, n_fail;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   function automatic rsp_t ref_op(int id, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
      rsp_t r;
      r.id = id;
      r.e  = 1'b0;
      case (op)
         3'd0:    r.d = a & b;
         3'd1:    r.d = a | b;
         3'd2:    r.d = ~a;
         3'd3:    r.d = ~(a & b);
         3'd4:    r.d = ~(a | b);
         3'd5:    r.d = a ^ b;
         default: begin r.d = '0; r.e = 1'b1; end
      endcase
      return r;
   endfunction

   task automatic drive();
      bus.req_valid_i = vld;
      for (int i = 0; i < N; i++) begin
         bus.req_op_i[3*i +: 3] = op_m[i];
         bus.req_a_i[W*i +: W]  = a_m[i];
         bus.req_b_i[W*i +: W]  = b_m[i];
      end
      bus.rsp_ready_i = rsp_rdy;
   endtask

   // One clock: drive, check at negedge against the model, advance model past the edge.
   task automatic cyc();
      logic [N-1:0] er;
      int   w, g, idx;
      bit   was_rst;
      rsp_t e;
      drive();
      @(negedge clk);
      cyc_n++;
      g = -1;
      was_rst = !rst_n;
      if (!rst_n) begin
         check("ready_in_reset", 32'(bus.req_ready_o), 0);
      end else begin
         if (rst_prev) begin
            check("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
            check("rst_rsp_data", 32'(bus.rsp_data_o), 0);
            check("rst_rsp_id", 32'(bus.rsp_id_o), 0);
            check("rst_rsp_err", 32'(bus.rsp_err_o), 0);
         end
`ifdef LU_ARB_STATS_EN
         for (int i = 0; i < N; i++)
            check($sformatf("grant_cnt%0d", i), 32'(gcnt[CNT_W*i +: CNT_W]), 32'(cnt_m[i]));
`endif
         if (outst == 0) begin
            er = '0;
            w  = -1;
            for (int k = 0; k < N; k++) begin
               idx = (rr_m + k) % N;
               if (w < 0 && vld[idx]) w = idx;
            end
            if (w >= 0) er[w] = 1'b1;
            check("ready", 32'(bus.req_ready_o), 32'(er));
            check("busy_idle", 32'(busy), 0);
            check("rsp_valid_idle", 32'(bus.rsp_valid_o), 0);
            if (w >= 0) begin
               exp_q.push_back(ref_op(w, op_m[w], a_m[w], b_m[w]));
               rr_m  = (w + 1) % N;
               outst = 1;
               since = 0;
               g     = w;
               glog.push_back(w);
               gcyc.push_back(cyc_n);
               if (cnt_m[w] < (1 << CNT_W) - 1) cnt_m[w]++;
            end
         end else begin
            since++;
            check("ready_busy", 32'(bus.req_ready_o), 0);
            check("busy", 32'(busy), 1);
            if (since == 1) begin
               check("rsp_valid_exec", 32'(bus.rsp_valid_o), 0);
            end else begin
               e = exp_q[0];
               check("rsp_valid", 32'(bus.rsp_valid_o), 1);
               check("rsp_data", 32'(bus.rsp_data_o), 32'(e.d));
               check("rsp_id", 32'(bus.rsp_id_o), 32'(e.id));
               check("rsp_err", 32'(bus.rsp_err_o), 32'(e.e));
               if (rsp_rdy) begin
                  last_d  = e.d;
                  last_id = e.id;
                  last_e  = e.e;
                  void'(exp_q.pop_front());
                  n_hs++;
                  outst = 0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      rst_prev = was_rst;
      if (was_rst) begin
         rr_m  = 0;
         outst = 0;
         exp_q.delete();
         for (int i = 0; i < N; i++) cnt_m[i] = 0;
      end else if (g >= 0 && !hold_all) begin
         vld[g] = 1'b0;
      end
   endtask

   task automatic wait_hs();
      int start, t;
      start = n_hs;
      t = 0;
      while (n_hs == start && t < 12) begin
         cyc();
         t++;
      end
      if (n_hs == start) check("rsp_timeout", 0, 1);
   endtask

   task automatic txn(int req, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
      op_m[req] = op;
      a_m[req]  = a;
      b_m[req]  = b;
      vld[req]  = 1'b1;
      wait_hs();
   endtask

   task automatic drain();
      int t;
      vld = '0;
      rsp_rdy = 1'b1;
      t = 0;
      while (outst != 0 && t < 10) begin
         cyc();
         t++;
      end
      if (outst != 0) check("drain_timeout", 0, 1);
   endtask

   initial begin
      logic [7:0] t3 [7];
      int s;
      t3 = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h00};
      n_chk = 0; n_fail = 0; cyc_n = 0; n_hs = 0;
      rr_m = 0; outst = 0; since = 0; hold_all = 0; rst_prev = 0;
      for (int i = 0; i < N; i++) begin
         op_m[i] = '0; a_m[i] = '0; b_m[i] = '0; cnt_m[i] = 0;
      end
      rsp_rdy = 1'b1;

      // Reset with every requester asserting valid.
      rst_n = 1'b0;
      vld = '1;
      cyc();
      cyc();
      rst_n = 1'b1;
      vld = '0;
      cyc();

      // Single XOR from requester 0.
      txn(0, 3'd5, 8'hF0, 8'h3C);
      check("xor_data", 32'(last_d), 32'h0CC);
      check("xor_id", 32'(last_id), 0);
      check("xor_err", 32'(last_e), 0);

      // Every opcode from requester 3 (leaves rr pointer at 0).
      for (int op = 0; op < 7; op++) begin
         txn(3, 3'(op), 8'hA5, 8'h0F);
         check($sformatf("op%0d_data", op), 32'(last_d), 32'(t3[op]));
         check($sformatf("op%0d_err", op), 32'(last_e), (op == 6) ? 1 : 0);
      end
      cyc();

      // Fairness with all requesters held valid.
      hold_all = 1;
      vld = '1;
      s = glog.size();
      for (int t = 0; t < 40 && glog.size() < s + 5; t++) cyc();
      hold_all = 0;
      if (glog.size() < s + 5) check("fair_timeout", 0, 1);
      else begin
         for (int i = 0; i < 5; i++) check($sformatf("fair_order%0d", i), 32'(glog[s+i]), 32'(i % N));
         for (int i = 1; i < 5; i++) check($sformatf("fair_gap%0d", i), 32'(gcyc[s+i] - gcyc[s+i-1]), 3);
      end
      drain();
      cyc();

      // Backpressure: response held for 5 extra cycles while others keep requesting.
      rsp_rdy = 1'b0;
      vld = '1;
      for (int t = 0; t < 8 && !(outst != 0 && since >= 2); t++) cyc();
      for (int t = 0; t < 5; t++) cyc();
      s = n_hs;
      rsp_rdy = 1'b1;
      cyc();
      check("bp_release", 32'(n_hs - s), 1);
      vld = '0;
      cyc();
      drain();

      // Randomized traffic.
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < N; i++) begin
            if (!vld[i]) begin
               if ($urandom_range(2) == 0) begin
                  vld[i]  = 1'b1;
                  op_m[i] = 3'($urandom_range(7));
                  a_m[i]  = W'($urandom);
                  b_m[i]  = W'($urandom);
               end
            end else if ($urandom_range(15) == 0) begin
               vld[i] = 1'b0;
            end
         end
         rsp_rdy = ($urandom_range(2) != 0);
         cyc();
      end
      drain();
      cyc();

      // Reset while in EXEC discards the transaction.
      op_m[1] = 3'd0; a_m[1] = 8'hFF; b_m[1] = 8'h81;
      vld[1] = 1'b1;
      cyc();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int t = 0; t < 4; t++) cyc();

      // Five grants to requester 1 (counter saturates at 3 when CNT_W=2).
      for (int t = 0; t < 5; t++) txn(1, 3'(t), 8'h3C, 8'h55);
      cyc();
`ifdef LU_ARB_STATS_EN
      check("grant_cnt1_sat", 32'(gcnt[CNT_W*1 +: CNT_W]), 3);
      check("grant_cnt0_clr", 32'(gcnt[CNT_W*0 +: CNT_W]), 0);
`endif
      check("final_id", 32'(last_id), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
